// File: rtl/async_ops_pkg.sv
// async_ops_pkg: shared defaults, pointer helper and protocol-error causes for async dataflow operators
package async_ops_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  typedef enum logic [1:0] {ERR_NONE, ERR_NO_REQ, ERR_DOUBLE_ACK} err_cause_t;
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return ptr == depth - 1 ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/async_buffer_mem.sv
// async_buffer_mem: DEPTH x DATA_WIDTH register array, one write port, one registered read port
module async_buffer_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [PTR_W-1:0]      wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [PTR_W-1:0]      ra,
  output logic [DATA_WIDTH-1:0] rd
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/async_elastic_buffer.sv
// async_elastic_buffer: DEPTH-entry elastic FIFO with pull-style req/ack on both sides
module async_elastic_buffer
  import async_ops_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = 4,
  parameter int OUTPUT_SIZE = 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   req_l,
  input  logic                   ack_l,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic [OUTPUT_SIZE-1:0] req_r,
  output logic                   ack_r,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic [CNT_W-1:0]       count,
  output logic                   proto_err
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_n;
  logic ack_l_q, wr, pop;
  err_cause_t cause;
  always_comb begin
    cause = !ack_l ? ERR_NONE : ack_l_q ? ERR_DOUBLE_ACK : !req_l ? ERR_NO_REQ : ERR_NONE;
    wr = ack_l && cause == ERR_NONE;
    pop = !ack_r && count != '0 && &req_r;
    count_n = count + CNT_W'(wr) - CNT_W'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_l <= 1'b0;
      ack_r <= 1'b0;
      count <= '0;
      proto_err <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ack_l_q <= 1'b0;
    end else begin
      req_l <= req_l ? !ack_l : (count_n < CNT_W'(DEPTH) && !ack_l);
      ack_r <= pop;
      count <= count_n;
      proto_err <= proto_err | (cause != ERR_NONE);
      ack_l_q <= ack_l;
      if (wr) wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
      if (pop) rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
    end
  async_buffer_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(wr),
    .wa(wr_ptr),
    .wd(din),
    .re(pop),
    .ra(rd_ptr),
    .rd(dout)
  );
endmodule

// File: tb/tb_async_elastic_buffer.sv
// tb_async_elastic_buffer: randomized bench against a queue-based model of the elastic buffer
module tb_async_elastic_buffer;
  localparam int DW = 32, DEPTH = 3, OS = 3, CNT_W = $clog2(DEPTH + 1);
  logic clk = 0, rst = 0, ack_l = 0, req_l, ack_r, proto_err;
  logic [DW-1:0] din = '0, dout;
  logic [OS-1:0] req_r = '0;
  logic [CNT_W-1:0] count;
  int checks = 0, errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_dout = '0;
  logic pend_wr = 0, pend_pop = 0, exp_req = 0, exp_err = 0;
  bit prod_en = 0, cons_rand = 0, force_bad = 0, saw_dead = 0;
  int prod_pct = 100, cons_pct = 100, next_word = 0, popped = 0, max_cnt = 0, cyc;
  logic [OS-1:0] cons_pat = '0;
  always #5 clk = ~clk;
  async_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OUTPUT_SIZE(OS)) dut (
    .clk(clk),
    .rst(rst),
    .req_l(req_l),
    .ack_l(ack_l),
    .din(din),
    .req_r(req_r),
    .ack_r(ack_r),
    .dout(dout),
    .count(count),
    .proto_err(proto_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (pend_wr) q.push_back(din);
    check("ack_r", 64'(ack_r), 64'(pend_pop));
    if (ack_r && q.size() > 0) begin
      if (dout == DW'(32'hDEAD)) saw_dead = 1;
      check("dout", 64'(dout), 64'(q.pop_front()));
      popped++;
    end else if (!ack_r) check("dout_hold", 64'(dout), 64'(last_dout));
    last_dout = dout;
    check("count", 64'(count), 64'(q.size()));
    check("req_l", 64'(req_l), 64'(exp_req));
    check("proto_err", 64'(proto_err), 64'(exp_err));
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (force_bad) begin
      ack_l = 1;
      din = DW'(32'hDEAD);
      exp_err = 1;
    end else begin
      ack_l = prod_en && req_l && ($urandom_range(99) < prod_pct);
      if (ack_l) din = DW'(next_word++);
    end
    req_r = cons_rand ? (($urandom_range(99) < cons_pct) ? '1 : OS'($urandom)) : cons_pat;
    pend_wr = ack_l && req_l;
    pend_pop = !ack_r && q.size() > 0 && (&req_r);
    exp_req = req_l ? !ack_l : (!ack_l && int'(q.size()) - int'(pend_pop) < DEPTH);
  endtask
  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("rst_req_l", 64'(req_l), 64'(0));
    check("rst_ack_r", 64'(ack_r), 64'(0));
    check("rst_dout", 64'(dout), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_proto_err", 64'(proto_err), 64'(0));
    q.delete();
    {pend_wr, pend_pop, exp_err, ack_l, force_bad, prod_en} = '0;
    exp_req = 1;
    last_dout = '0;
    req_r = '0;
    cons_pat = '0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    apply_reset();
    prod_en = 1;
    repeat (20) step();
    prod_en = 0;
    check("fill_count", 64'(count), 64'(DEPTH));
    check("fill_words", 64'(next_word), 64'(DEPTH));
    check("fill_req_l", 64'(req_l), 64'(0));
    cons_pat = 3'b011;
    repeat (10) step();
    check("gate_count", 64'(count), 64'(DEPTH));
    check("gate_popped", 64'(popped), 64'(0));
    cons_pat = '1;
    step();
    step();
    check("first_pop", 64'(popped), 64'(1));
    check("first_dout", 64'(dout), 64'(0));
    repeat (12) step();
    check("drain_popped", 64'(popped), 64'(DEPTH));
    check("drain_count", 64'(count), 64'(0));
    popped = 0;
    prod_en = 1;
    for (cyc = 0; cyc < 12000 && popped < 5000; cyc++) step();
    check("stream_words", 64'(popped), 64'(5000));
    check("stream_rate", 64'(cyc <= 10010), 64'(1));
    prod_en = 0;
    repeat (10) step();
    check("stream_empty", 64'(count), 64'(0));
    popped = 0;
    prod_en = 1;
    prod_pct = 50;
    cons_rand = 1;
    cons_pct = 40;
    for (cyc = 0; cyc < 3000 && popped < 100; cyc++) step();
    check("stall_words", 64'(popped >= 100), 64'(1));
    check("stall_max_count", 64'(max_cnt <= DEPTH), 64'(1));
    cons_rand = 0;
    cons_pat = '0;
    prod_pct = 100;
    repeat (10) step();
    prod_en = 0;
    check("err_pre_count", 64'(count), 64'(DEPTH));
    force_bad = 1;
    step();
    force_bad = 0;
    step();
    check("err_no_req", 64'(proto_err), 64'(1));
    check("err_count", 64'(count), 64'(DEPTH));
    cons_pat = '1;
    repeat (10) step();
    check("err_sticky", 64'(proto_err), 64'(1));
    check("err_no_dead", 64'(saw_dead), 64'(0));
    prod_en = 1;
    repeat (7) step();
    apply_reset();
    prod_en = 1;
    for (cyc = 0; cyc < 10 && !pend_wr; cyc++) step();
    check("dbl_setup", 64'(pend_wr), 64'(1));
    force_bad = 1;
    step();
    force_bad = 0;
    prod_en = 0;
    step();
    check("err_double_ack", 64'(proto_err), 64'(1));
    check("dbl_count", 64'(count), 64'(1));
    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/async_elastic_buffer.md
Name: async_elastic_buffer

Overview:
- Parametrised successor of the fixed single-slot "reg" stage in the asynchronous-dataflow operator library. Pipeline balancing currently chains several one-entry reg operators; this block replaces such a chain.
- Provides a DEPTH-entry elastic FIFO using the same pull-style req/ack protocol.
  - Upstream side: the block requests data.
  - Downstream side: OUTPUT_SIZE consumers all request; one ack is returned.
- Adds occupancy reporting and a sticky protocol-error flag, which single-slot stages lack.

Parameters:
- DATA_WIDTH, 32: payload width in bits.
- DEPTH, 4: number of storage entries, >=1. Need not be a power of two.
- OUTPUT_SIZE, 1: number of downstream request lines ANDed together, >=1.
- CNT_W, $clog2(DEPTH+1): width of the occupancy counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_l  out  1  request to the upstream producer.
- ack_l  in  1  upstream ack pulse; din is valid while ack_l=1.
- din  in  DATA_WIDTH  upstream data.
- req_r  in  OUTPUT_SIZE  downstream requests.
- ack_r  out  1  downstream ack pulse.
- dout  out  DATA_WIDTH  downstream data.
- count  out  CNT_W  current occupancy.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - req_l=0, ack_r=0, dout=0, count=0, proto_err=0.
  - Read/write pointers = 0.
  - Storage contents are don't-care.
- Upstream fill, registered, one decision per cycle:
  - If req_l=0 and count_next<DEPTH and not in the post-ack cycle: req_l<=1.
  - While req_l=1, req_l is held until ack_l=1.
  - On a cycle with ack_l=1 and req_l=1: din is written at wr_ptr, wr_ptr advances and wraps at DEPTH-1 to 0, and req_l<=0.
  - req_l stays low for at least one cycle after each ack. This matches the producer's ack&~ack rhythm, giving a maximum fill rate of 1 word per 2 cycles.
  - Data is captured synchronously on clk. It is never captured on an ack edge.
- Full: req_l is never asserted when count=DEPTH.
  - A write coinciding with a pop in the same cycle keeps count unchanged.
  - The next request is issued based on count_next.
- Downstream drain:
  - Condition: ack_r=0, count>0 and &req_r=1.
  - Next cycle: ack_r=1 and dout=mem[rd_ptr]; rd_ptr advances with wrap.
  - ack_r is a single-cycle pulse. It is forced to 0 the cycle after it was 1, so pops occur at most 1 per 2 cycles.
  - dout holds its value until the next pop.
- Empty: ack_r stays 0 regardless of req_r. There is no bypass: minimum latency from ack_l to ack_r is 2 cycles.
- Simultaneous write and pop: both take effect. count = count+1-1. When DEPTH=1 and full, a pop frees the slot and req_l may rise the following cycle.
- count: registered, equal to writes minus pops. It is always in 0..DEPTH.
- proto_err is set and held until reset on either of:
  - ack_l=1 while req_l=0;
  - ack_l=1 on two consecutive cycles.
  - The offending data is dropped and count is unchanged.
- Reset mid-operation: all state clears immediately, in-flight data is lost and req_l drops without waiting for ack.
- No arithmetic on data; width is preserved.

Decomposition:
- Shared package (async_ops_pkg): default DATA_WIDTH, a ptr_inc helper that wraps at DEPTH-1, and the proto_err cause encoding (reused by future operators).
- One sub-module, async_buffer_mem: a DEPTH x DATA_WIDTH register array with one write port and one registered read port. Pointer, count and handshake control stay in the top module.

Test Plan:
- Reset then idle: DEPTH=4, OUTPUT_SIZE=1, req_r=0, producer incrementing from 0 -> 4 words accepted, count=4, req_l=0 thereafter, ack_r=0, proto_err=0.
- Drain: after the fill above, req_r=1 -> ack_r pulses every 2 cycles with dout=0,1,2,3; count steps 3,2,1,0; ack_r then stays 0.
- Steady-state streaming: 5000 words, both sides at fail rate 0 -> consumer sees 0..4999 in order, no gaps or duplicates, throughput 50% of cycles.
- Fan-out gating: OUTPUT_SIZE=3, req_r=3'b011 for 10 cycles -> no pop. Then 3'b111 -> first pop within 1 cycle, dout=0.
- Wrap/non-power-of-two with random stalls: DEPTH=3, random stalls on both ends, 100 words -> in-order data across pointer wrap, count never exceeds 3.
- Protocol violation: force ack_l=1 with req_l=0, din=0xDEAD -> proto_err=1 sticky, count unchanged, 0xDEAD never appears on dout. Then assert rst mid-stream -> all outputs return to 0 in the same cycle.
